// File: rtl/sitcp_tx_arbiter.sv
// Round-robin multiplexer of FWFT byte sources onto the SiTCP TCP TX stream.
// Every grant sends a tag byte {101, CONT, src} followed by up to BURST_LEN payload bytes.
module sitcp_tx_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int BURST_LEN = 256
) (
  input  logic                 CLK_100M,
  input  logic                 SiTCP_RESET,
  input  logic                 TCP_OPEN_ACK,
  input  logic                 TCP_TX_FULL,
  input  logic [8*NUM_SRC-1:0] SRC_DATA,
  input  logic [NUM_SRC-1:0]   SRC_VALID,
  input  logic [NUM_SRC-1:0]   SRC_LAST,
  output logic [NUM_SRC-1:0]   SRC_RD,
  output logic                 TCP_TX_WR,
  output logic [7:0]           TCP_TX_DATA,
  output logic [NUM_SRC-1:0]   GRANT,
  output logic                 BUSY,
  output logic                 ERR_ABORT
);

  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [15:0]        LAST_CNT = 16'(BURST_LEN - 1);
  localparam logic [NUM_SRC-1:0] ONE      = 1;

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t             state_q;
  logic [IW-1:0]      ptr_q, g_q;
  logic [NUM_SRC-1:0] cont_q, grant_q;
  logic [15:0]        cnt_q;
  logic               wr_q, abort_q;
  logic [7:0]         data_q;

  logic [IW-1:0] sel_d;
  logic          sel_vld;
  int            cand;

  // First valid source strictly after the last served one, wrapping around.
  always_comb begin
    sel_d   = '0;
    sel_vld = 1'b0;
    cand    = 0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= NUM_SRC) cand = cand - NUM_SRC;
      if (!sel_vld && SRC_VALID[IW'(cand)]) begin
        sel_vld = 1'b1;
        sel_d   = IW'(cand);
      end
    end
  end

  logic       pop, burst_end;
  logic [7:0] hdr_byte, src_byte;

  assign pop       = (state_q == DATA) & TCP_OPEN_ACK & ~TCP_TX_FULL & SRC_VALID[g_q];
  assign burst_end = SRC_LAST[g_q] | (cnt_q == LAST_CNT);
  assign hdr_byte  = {3'b101, cont_q[g_q], 4'(g_q)};
  assign src_byte  = SRC_DATA[{g_q, 3'b000} +: 8];

  assign SRC_RD      = pop ? grant_q : '0;
  assign TCP_TX_WR   = wr_q;
  assign TCP_TX_DATA = data_q;
  assign GRANT       = grant_q;
  assign BUSY        = (state_q != IDLE);
  assign ERR_ABORT   = abort_q;

  always_ff @(posedge CLK_100M or posedge SiTCP_RESET) begin
    if (SiTCP_RESET) begin
      state_q <= IDLE;
      ptr_q   <= IW'(NUM_SRC - 1);
      g_q     <= '0;
      cont_q  <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      abort_q <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      wr_q    <= 1'b0;
      abort_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!TCP_OPEN_ACK) begin
            cont_q <= '0;
          end else if (sel_vld) begin
            grant_q <= ONE << sel_d;
            g_q     <= sel_d;
            cnt_q   <= '0;
            state_q <= HDR;
          end
        end
        HDR: begin
          if (!TCP_OPEN_ACK) begin
            state_q <= IDLE;
            grant_q <= '0;
            cont_q  <= '0;
            abort_q <= 1'b1;
          end else if (!TCP_TX_FULL) begin
            wr_q    <= 1'b1;
            data_q  <= hdr_byte;
            state_q <= DATA;
          end
        end
        DATA: begin
          if (!TCP_OPEN_ACK) begin
            state_q <= IDLE;
            grant_q <= '0;
            cont_q  <= '0;
            abort_q <= 1'b1;
          end else if (pop) begin
            wr_q   <= 1'b1;
            data_q <= src_byte;
            cnt_q  <= cnt_q + 16'd1;
            // A burst cut short of LAST leaves the frame open for the next grant.
            if (burst_end) begin
              cont_q[g_q] <= ~SRC_LAST[g_q];
              ptr_q       <= g_q;
              grant_q     <= '0;
              state_q     <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sitcp_tx_arbiter.sv
// Randomised bench for sitcp_tx_arbiter: array-backed FWFT sources, a stream monitor,
// and a frame-level model of the tagged output byte stream.
module tb_sitcp_tx_arbiter;
  localparam int NS    = 4;
  localparam int BL    = 4;
  localparam int DEPTH = 1024;

  logic            CLK_100M = 1'b0;
  logic            SiTCP_RESET, TCP_OPEN_ACK, TCP_TX_FULL;
  logic [8*NS-1:0] SRC_DATA;
  logic [NS-1:0]   SRC_VALID, SRC_LAST, SRC_RD, GRANT;
  logic            TCP_TX_WR, BUSY, ERR_ABORT;
  logic [7:0]      TCP_TX_DATA;

  sitcp_tx_arbiter #(.NUM_SRC(NS), .BURST_LEN(BL)) dut (
    .CLK_100M(CLK_100M), .SiTCP_RESET(SiTCP_RESET), .TCP_OPEN_ACK(TCP_OPEN_ACK),
    .TCP_TX_FULL(TCP_TX_FULL), .SRC_DATA(SRC_DATA), .SRC_VALID(SRC_VALID),
    .SRC_LAST(SRC_LAST), .SRC_RD(SRC_RD), .TCP_TX_WR(TCP_TX_WR),
    .TCP_TX_DATA(TCP_TX_DATA), .GRANT(GRANT), .BUSY(BUSY), .ERR_ABORT(ERR_ABORT)
  );

  always #5 CLK_100M = ~CLK_100M;

  // Source FIFOs: the initial block appends at tail, the pop process advances head.
  logic [7:0] sdat  [NS][DEPTH];
  bit         slast [NS][DEPTH];
  int         head  [NS] = '{default: 0};
  int         tail  [NS] = '{default: 0};

  for (genvar gi = 0; gi < NS; gi++) begin : g_src
    assign SRC_VALID[gi]        = head[gi] < tail[gi];
    assign SRC_DATA[gi*8 +: 8]  = sdat[gi][head[gi][9:0]];
    assign SRC_LAST[gi]         = slast[gi][head[gi][9:0]];
  end

  always @(posedge CLK_100M)
    for (int i = 0; i < NS; i++)
      if (SRC_RD[i]) head[i] <= head[i] + 1;

  logic [7:0] obs  [4096];
  int         wcyc [4096];
  int         obs_n = 0, cyc = 0, err_cnt = 0;
  int         rd_cnt [NS] = '{default: 0};

  always @(negedge CLK_100M) begin
    cyc <= cyc + 1;
    if (TCP_TX_WR && obs_n < 4096) begin
      obs[obs_n]  <= TCP_TX_DATA;
      wcyc[obs_n] <= cyc;
      obs_n       <= obs_n + 1;
    end
    for (int i = 0; i < NS; i++)
      if (SRC_RD[i]) rd_cnt[i] <= rd_cnt[i] + 1;
    if (ERR_ABORT) err_cnt <= err_cnt + 1;
  end

  int total = 0, bad = 0;

  // Model: what the host should receive for everything currently queued.
  int            m_ptr = NS - 1;
  logic [NS-1:0] m_cont = '0;
  logic [7:0]    exp_q[$];

  task automatic model();
    int h[NS];
    int g, c, j;
    bit found, done;
    exp_q.delete();
    for (int i = 0; i < NS; i++) h[i] = head[i];
    forever begin
      found = 0; g = 0;
      for (int k = 1; k <= NS; k++) begin
        j = (m_ptr + k) % NS;
        if (!found && h[j] < tail[j]) begin found = 1; g = j; end
      end
      if (!found) break;
      exp_q.push_back({3'b101, m_cont[g], 4'(g)});
      c = 0; done = 0;
      while (!done) begin
        exp_q.push_back(sdat[g][h[g][9:0]]);
        c++;
        if (slast[g][h[g][9:0]] || c == BL) begin
          m_cont[g] = !slast[g][h[g][9:0]];
          done = 1;
        end
        h[g]++;
      end
      m_ptr = g;
    end
  endtask

  task automatic push(input int s, input logic [7:0] b, input bit last);
    sdat[s][tail[s][9:0]]  = b;
    slast[s][tail[s][9:0]] = last;
    tail[s]++;
  endtask

  task automatic push_rand(input int s, input int len);
    for (int j = 0; j < len; j++) push(s, 8'($urandom), j == len - 1);
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NS; i++) if (head[i] != tail[i]) return 0;
    return 1;
  endfunction

  task automatic drain(input bit rfull, input string nm);
    bit ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(posedge CLK_100M); #1;
      if (all_empty() && !BUSY) ok = 1;
      else TCP_TX_FULL = rfull ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
    TCP_TX_FULL = 1'b0;
    repeat (2) @(posedge CLK_100M);
    #1;
    total++;
    if (!ok) begin bad++; $display("FAIL %s_drain: still busy after 3000 cycles, required idle", nm); end
  endtask

  task automatic test_reset();
    SiTCP_RESET = 1; TCP_OPEN_ACK = 0; TCP_TX_FULL = 0;
    repeat (3) @(posedge CLK_100M);
    @(negedge CLK_100M);
    total++;
    if ({TCP_TX_WR, TCP_TX_DATA, GRANT, BUSY, ERR_ABORT, SRC_RD} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: wr=%b data=%h grant=%b busy=%b err=%b rd=%b, required all 0",
               TCP_TX_WR, TCP_TX_DATA, GRANT, BUSY, ERR_ABORT, SRC_RD);
    end
    @(posedge CLK_100M); #1;
    SiTCP_RESET = 0;
    m_ptr = NS - 1; m_cont = '0;
  endtask

  task automatic test_single();
    int s, r0;
    s = obs_n; r0 = rd_cnt[0];
    push(0, 8'h11, 0); push(0, 8'h22, 0); push(0, 8'h33, 1);
    model();
    TCP_OPEN_ACK = 1;
    @(posedge CLK_100M); @(negedge CLK_100M);
    total++;
    if (GRANT !== 4'b0001) begin bad++; $display("FAIL single_grant: got %b, required 0001", GRANT); end
    drain(0, "single");
    total++;
    if (GRANT !== 4'b0000) begin bad++; $display("FAIL single_grant_end: got %b, required 0000", GRANT); end
    total++;
    if (rd_cnt[0] - r0 != 3) begin bad++; $display("FAIL single_rd: got %0d pulses, required 3", rd_cnt[0] - r0); end
    total++;
    if (obs_n - s != exp_q.size()) begin
      bad++; $display("FAIL single_len: got %0d bytes, required %0d", obs_n - s, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && s + i < obs_n; i++) begin
      total++;
      if (obs[s+i] !== exp_q[i]) begin
        bad++; $display("FAIL single_byte[%0d]: got %h, required %h", i, obs[s+i], exp_q[i]);
      end
    end
    total++;
    if (obs[s] !== 8'hA0 || wcyc[s+3] - wcyc[s] != 3) begin
      bad++; $display("FAIL single_timing: hdr=%h span=%0d, required A0 and 3", obs[s], wcyc[s+3] - wcyc[s]);
    end
  endtask

  task automatic test_rr();
    int s;
    s = obs_n;
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < NS; i++) push_rand(i, 1);
    model();
    drain(0, "rr");
    total++;
    if (obs_n - s != exp_q.size()) begin
      bad++; $display("FAIL rr_len: got %0d bytes, required %0d", obs_n - s, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && s + i < obs_n; i++) begin
      total++;
      if (obs[s+i] !== exp_q[i]) begin
        bad++; $display("FAIL rr_byte[%0d]: got %h, required %h", i, obs[s+i], exp_q[i]);
      end
    end
  endtask

  task automatic test_burst();
    int s;
    s = obs_n;
    push_rand(1, 6);
    push_rand(1, 1);
    model();
    drain(0, "burst");
    total++;
    if (obs[s] !== 8'hA1 || obs[s+5] !== 8'hB1 || obs[s+8] !== 8'hA1) begin
      bad++; $display("FAIL burst_hdrs: got %h %h %h, required A1 B1 A1", obs[s], obs[s+5], obs[s+8]);
    end
    for (int i = 0; i < exp_q.size() && s + i < obs_n; i++) begin
      total++;
      if (obs[s+i] !== exp_q[i]) begin
        bad++; $display("FAIL burst_byte[%0d]: got %h, required %h", i, obs[s+i], exp_q[i]);
      end
    end
  endtask

  task automatic test_stall();
    int s;
    bit seen = 0;
    s = obs_n;
    push_rand(0, 8);
    model();
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge CLK_100M);
      if (SRC_RD[0]) seen = 1;
    end
    total++;
    if (!seen) begin bad++; $display("FAIL stall_start: no SRC_RD within 20 cycles, required one"); end
    @(posedge CLK_100M); #1;
    TCP_TX_FULL = 1;
    for (int j = 0; j < 5; j++) begin
      @(negedge CLK_100M);
      total++;
      if (SRC_RD !== '0) begin bad++; $display("FAIL stall_rd[%0d]: got %b, required 0000", j, SRC_RD); end
      if (j > 0) begin
        total++;
        if (TCP_TX_WR !== 1'b0) begin bad++; $display("FAIL stall_wr[%0d]: got %b, required 0", j, TCP_TX_WR); end
      end
      @(posedge CLK_100M); #1;
    end
    TCP_TX_FULL = 0;
    drain(0, "stall");
    total++;
    if (obs_n - s != exp_q.size()) begin
      bad++; $display("FAIL stall_len: got %0d bytes, required %0d", obs_n - s, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && s + i < obs_n; i++) begin
      total++;
      if (obs[s+i] !== exp_q[i]) begin
        bad++; $display("FAIL stall_byte[%0d]: got %h, required %h", i, obs[s+i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    int s;
    s = obs_n;
    for (int f = 0; f < 30; f++) push_rand($urandom_range(0, NS - 1), $urandom_range(1, 9));
    model();
    drain(1, "random");
    total++;
    if (obs_n - s != exp_q.size()) begin
      bad++; $display("FAIL random_len: got %0d bytes, required %0d", obs_n - s, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && s + i < obs_n; i++) begin
      total++;
      if (obs[s+i] !== exp_q[i]) begin
        bad++; $display("FAIL random_byte[%0d]: got %h, required %h", i, obs[s+i], exp_q[i]);
      end
    end
  endtask

  task automatic test_abort();
    int s, e0, n;
    logic [7:0] b2;
    s = obs_n; n = 0;
    b2 = 8'($urandom);
    push(2, 8'($urandom), 0); push(2, 8'($urandom), 0); push(2, b2, 0);
    push(2, 8'($urandom), 0); push(2, 8'($urandom), 0); push(2, 8'($urandom), 1);
    for (int i = 0; i < 30 && n < 2; i++) begin
      @(negedge CLK_100M);
      if (SRC_RD[2]) n++;
    end
    @(posedge CLK_100M); #1;
    TCP_OPEN_ACK = 0;
    e0 = err_cnt;
    repeat (6) @(posedge CLK_100M);
    #1;
    total++;
    if (err_cnt - e0 != 1) begin bad++; $display("FAIL abort_pulses: got %0d, required 1", err_cnt - e0); end
    total++;
    if (GRANT !== '0 || BUSY !== 1'b0) begin
      bad++; $display("FAIL abort_idle: grant=%b busy=%b, required 0000 and 0", GRANT, BUSY);
    end
    total++;
    if (obs_n - s != 3 || obs[s] !== 8'hA2) begin
      bad++; $display("FAIL abort_writes: got %0d bytes hdr %h, required 3 bytes hdr A2", obs_n - s, obs[s]);
    end
    s = obs_n;
    m_cont = '0;
    model();
    TCP_OPEN_ACK = 1;
    drain(0, "abort");
    total++;
    if (obs[s] !== 8'hA2 || obs[s+1] !== b2) begin
      bad++; $display("FAIL abort_resume: got %h %h, required A2 %h", obs[s], obs[s+1], b2);
    end
    for (int i = 0; i < exp_q.size() && s + i < obs_n; i++) begin
      total++;
      if (obs[s+i] !== exp_q[i]) begin
        bad++; $display("FAIL abort_byte[%0d]: got %h, required %h", i, obs[s+i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int s;
    bit seen = 0;
    for (int i = 0; i < NS; i++) push_rand(i, 6);
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge CLK_100M);
      if (GRANT === 4'b0100) seen = 1;
    end
    @(negedge CLK_100M);
    #1;
    SiTCP_RESET = 1;
    #1;
    total++;
    if (!seen || TCP_TX_WR !== 1'b0 || GRANT !== '0 || BUSY !== 1'b0 || SRC_RD !== '0) begin
      bad++;
      $display("FAIL rstmid_async: seen=%b wr=%b grant=%b busy=%b rd=%b, required seen and all 0",
               seen, TCP_TX_WR, GRANT, BUSY, SRC_RD);
    end
    m_ptr = NS - 1; m_cont = '0;
    model();
    @(posedge CLK_100M); #1;
    SiTCP_RESET = 0;
    s = obs_n;
    @(posedge CLK_100M); @(negedge CLK_100M);
    total++;
    if (GRANT !== 4'b0001) begin bad++; $display("FAIL rstmid_first: got %b, required 0001", GRANT); end
    drain(0, "rstmid");
    total++;
    if (obs_n - s != exp_q.size()) begin
      bad++; $display("FAIL rstmid_len: got %0d bytes, required %0d", obs_n - s, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && s + i < obs_n; i++) begin
      total++;
      if (obs[s+i] !== exp_q[i]) begin
        bad++; $display("FAIL rstmid_byte[%0d]: got %h, required %h", i, obs[s+i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr();
    test_burst();
    test_stall();
    test_random();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sitcp_tx_arbiter.md
# sitcp_tx_arbiter

Round-robin scheduler that shares the SiTCP TCP transmit byte stream (TCP_TX_WR/TCP_TX_DATA, throttled by TCP_TX_FULL) among up to 16 first-word-fall-through byte sources. Each grant emits a one-byte header followed by up to BURST_LEN payload bytes, so the host can demultiplex the sources. It sits between the user data FIFOs and the SiTCP wrapper's TCP TX port. It runs only while TCP_OPEN_ACK is high.

## Interface
Parameters:
- NUM_SRC, default 4: number of sources, 2..16.
- BURST_LEN, default 256: maximum payload bytes per grant, 1..65535.

Ports:
- CLK_100M  in  1  system clock.
- SiTCP_RESET  in  1  reset, asynchronous, active-high.
- TCP_OPEN_ACK  in  1  connection established; low forces the block to idle.
- TCP_TX_FULL  in  1  SiTCP almost-full flag.
- SRC_DATA  in  8*NUM_SRC  FWFT data; source i occupies bits [8i+7:8i].
- SRC_VALID  in  NUM_SRC  source i has a byte presented.
- SRC_LAST  in  NUM_SRC  presented byte is the last byte of the frame.
- SRC_RD  out  NUM_SRC  pop strobe (combinational).
- TCP_TX_WR  out  1  write enable to SiTCP (registered).
- TCP_TX_DATA  out  8  write data to SiTCP (registered).
- GRANT  out  NUM_SRC  one-hot current grant (registered).
- BUSY  out  1  high in HDR or DATA.
- ERR_ABORT  out  1  one-cycle pulse when a grant is aborted by TCP_OPEN_ACK falling.

## Operation
- FSM states: IDLE, HDR, DATA.
- IDLE:
  - If TCP_OPEN_ACK is high and SRC_VALID is nonzero, select the first valid source searching from (PTR+1) mod NUM_SRC upward.
  - Load GRANT and go to HDR.
  - PTR resets to NUM_SRC-1, so source 0 is checked first.
- HDR:
  - When TCP_TX_FULL is low, write the header byte and go to DATA.
  - Header byte = {3'b101, CONT[g], g[3:0]}.
  - CONT[g] is set when the previous grant to g ended on BURST_LEN without SRC_LAST.
- DATA:
  - pop = TCP_OPEN_ACK & ~TCP_TX_FULL & SRC_VALID[g].
  - SRC_RD[g] = pop. On pop: TCP_TX_WR<=1, TCP_TX_DATA<=SRC_DATA[g], CNT<=CNT+1.
  - CNT is 16-bit and cleared on entry to HDR.
  - The grant ends on pop when SRC_LAST[g] is high, or when CNT==BURST_LEN-1.
  - On grant end: CONT[g]<=~SRC_LAST[g], PTR<=g, GRANT<=0, go to IDLE.
  - If SRC_VALID[g] is low, wait indefinitely; the grant is not released mid-frame.
- Abort: TCP_OPEN_ACK low while in HDR or DATA causes:
  - next state IDLE, GRANT<=0, all CONT<=0;
  - ERR_ABORT high for one cycle;
  - no further writes.
  - PTR is unchanged.
  - The block does not flush source contents.
- TCP_OPEN_ACK low in IDLE: stay in IDLE and clear CONT.
- SRC_RD is nonzero only in DATA, only on the granted bit, and only when pop is true.
- If SRC_LAST and CNT==BURST_LEN-1 occur together, CONT is cleared (frame complete).
- Reset values: TCP_TX_WR=0, TCP_TX_DATA=8'h00, GRANT=0, BUSY=0, ERR_ABORT=0, SRC_RD=0, state IDLE, PTR=NUM_SRC-1, CONT=0, CNT=0.
- SiTCP_RESET asserted mid-operation clears everything immediately; partial frames are lost.

## Timing
- IDLE→HDR takes 1 cycle.
- The header appears on TCP_TX_WR the cycle after the first HDR cycle with FULL low.
- Payload byte k appears on TCP_TX_WR the cycle after its SRC_RD pulse.
- Best case per grant of N bytes: N+2 cycles (IDLE, HDR, N×DATA). TCP_TX_WR is high for N+1 of them.
- TCP_TX_FULL affects the same cycle's write decision; at most 1 write lands after FULL rises, which is within SiTCP almost-full margin.
- Source must update SRC_DATA/VALID/LAST the cycle after SRC_RD (FWFT).
- ERR_ABORT pulses in the cycle after TCP_OPEN_ACK is sampled low.

## Test plan
- Source 0 only, frame 8'h11,8'h22,8'h33 with LAST on 33, FULL=0 → TCP_TX_DATA A0,11,22,33 on 4 consecutive WR cycles; GRANT=0001 then 0000; 3 SRC_RD[0] pulses.
- All 4 sources valid, 1-byte frames, repeated → headers A0,A1,A2,A3,A0… with each header followed by one payload byte; no source starved.
- BURST_LEN=4, source 1 alone, 6-byte frame b0..b5 → A1,b0,b1,b2,b3, then B1,b4,b5; after LAST, next header is A1 again.
- TCP_TX_FULL high for 5 cycles mid-DATA → zero SRC_RD and zero WR during the stall; the byte sequence resumes with no loss or duplication.
- TCP_OPEN_ACK dropped after 2 payload bytes of source 2 → exactly one ERR_ABORT pulse, GRANT=0, no further WR. On reopen, the header is A2-form (CONT=0), or the next source per PTR.
- SiTCP_RESET pulsed mid-DATA → TCP_TX_WR, GRANT, BUSY and SRC_RD are 0 without a clock edge. After release, the first grant goes to source 0 when all sources are valid.
